// File: rtl/srff_lock_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | srff_lock_arbiter : round-robin owner of one external SR-flop lock flag    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module srff_lock_arbiter #(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int HOLD_MAX = 16,
  parameter int CONF_MAX = 4,
  parameter int CNT_W    = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] rel,
  input  logic             srff_q,
  output logic             srff_s,
  output logic             srff_r,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  owner_id,
  output logic             busy,
  output logic             timeout_err,
  output logic             fault
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_HOLD  = 3'd2,
    S_CLEAR = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CONF_LAST = CNT_W'(CONF_MAX - 1);
  localparam logic [CNT_W-1:0] HOLD_LIM  = CNT_W'(HOLD_MAX);
  localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(N_REQ - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    owner_q, owner_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic               s_q, s_d, r_q, r_d;
  logic               busy_q, busy_d, tmo_q, tmo_d, fault_q, fault_d;
  logic               pick_valid;
  logic [ID_W-1:0]    pick_id;

  // Scan from the farthest offset down so the requester nearest the pointer wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr_q) + i) % N_REQ]) begin
        pick_valid = 1'b1;
        pick_id    = ID_W'((int'(ptr_q) + i) % N_REQ);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    tmo_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          owner_d = pick_id;
          cnt_d   = '0;
          state_d = S_SET;
        end
      end
      S_SET: begin
        if (srff_q) begin
          state_d = S_HOLD;
          cnt_d   = CNT_W'(1);
        end else if (cnt_q == CONF_LAST) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_HOLD: begin
        // A voluntary release outranks the hold limit when both land together.
        if (rel[owner_q] || !req[owner_q]) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_LIM) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_CLEAR: begin
        if (!srff_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ptr_d   = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;
        end else if (cnt_q == CONF_LAST) begin
          state_d = S_FAULT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase

    s_d     = (state_d == S_SET);
    r_d     = (state_d == S_CLEAR);
    busy_d  = (state_d != S_IDLE);
    fault_d = (state_d == S_FAULT);
    grant_d = (state_d == S_HOLD) ? (N_REQ'(1) << owner_d) : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
      s_q     <= s_d;
      r_q     <= r_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      fault_q <= fault_d;
    end
  end

  assign srff_s      = s_q;
  assign srff_r      = r_q;
  assign grant       = grant_q;
  assign owner_id    = owner_q;
  assign busy        = busy_q;
  assign timeout_err = tmo_q;
  assign fault       = fault_q;

endmodule
`default_nettype wire
